// File: rtl/alu_mc.sv
// alu_mc: multi-cycle unsigned integer ALU (add, sub, mult, div) with a
// start/busy/done handshake. Add, sub and mult complete in the cycle after the
// request. Divide runs a restoring divider, one quotient bit per cycle, and
// also returns the remainder.
//
// Optional build macro: ALU_MC_SAT_EN. When it is defined, add and mult
// overflow saturate to all ones and a sub borrow saturates to zero. Without
// it, results wrap. In both builds ovf_o still flags the event.
//
// Parameters:
//   WIDTH    operand/result width in bits (>= 4)
//   ERR_VAL  result on divide-by-zero, truncated to WIDTH bits
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       synchronous active-low reset
//   op_i         0=add, 1=sub, 2=mult, 3=div
//   start_i      request, sampled only while busy_o=0
//   operand_a_i  first operand (dividend / minuend)
//   operand_b_i  second operand (divisor / subtrahend)
//   result_o     result (quotient for div)
//   remainder_o  div remainder, 0 after add/sub/mult
//   busy_o       high while a divide is in progress
//   done_o       one-cycle pulse: result/remainder/flags valid
//   ovf_o        overflow/borrow of last completed op
//   err_o        divide-by-zero on last completed op
module alu_mc #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned ERR_VAL = 9999
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       op_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic             err_o
);

`ifdef ALU_MC_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  localparam int unsigned     CntW   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ErrVal = WIDTH'(ERR_VAL);

  typedef enum logic [0:0] {StIdle, StDiv} state_e;
  typedef enum logic [1:0] {OpAdd = 2'd0, OpSub = 2'd1, OpMul = 2'd2, OpDiv = 2'd3} op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic               prod_hi;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_sub;
  logic               q_bit;
  logic [WIDTH-1:0]   prem_next;
  logic [WIDTH-1:0]   quot_next;

  always_comb begin
    sum     = {1'b0, operand_a_i} + {1'b0, operand_b_i};
    diff    = {1'b0, operand_a_i} - {1'b0, operand_b_i};
    prod    = {{WIDTH{1'b0}}, operand_a_i} * {{WIDTH{1'b0}}, operand_b_i};
    prod_hi = |prod[2*WIDTH-1:WIDTH];

    // Restoring step: the extra top bit of rem_sub is the borrow of the trial
    // subtraction; no borrow means the divisor fits and the quotient bit is 1.
    rem_shift = {prem_q, dividend_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, divisor_q};
    q_bit     = ~rem_sub[WIDTH];
    prem_next = q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quot_next = {quot_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    err_d       = err_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    prem_d      = prem_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          unique case (op_e'(op_i))
            OpAdd: begin
              result_d    = (SatEn && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
              remainder_d = '0;
              ovf_d       = sum[WIDTH];
              err_d       = 1'b0;
              done_d      = 1'b1;
            end
            OpSub: begin
              result_d    = (SatEn && diff[WIDTH]) ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
              remainder_d = '0;
              ovf_d       = diff[WIDTH];
              err_d       = 1'b0;
              done_d      = 1'b1;
            end
            OpMul: begin
              result_d    = (SatEn && prod_hi) ? {WIDTH{1'b1}} : prod[WIDTH-1:0];
              remainder_d = '0;
              ovf_d       = prod_hi;
              err_d       = 1'b0;
              done_d      = 1'b1;
            end
            OpDiv: begin
              if (operand_b_i == '0) begin
                result_d    = ErrVal;
                remainder_d = '0;
                ovf_d       = 1'b0;
                err_d       = 1'b1;
                done_d      = 1'b1;
              end else begin
                state_d    = StDiv;
                dividend_d = operand_a_i;
                divisor_d  = operand_b_i;
                prem_d     = '0;
                quot_d     = '0;
                cnt_d      = CntW'(WIDTH);
              end
            end
            default: ;
          endcase
        end
      end
      StDiv: begin
        dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
        prem_d     = prem_next;
        quot_d     = quot_next;
        cnt_d      = cnt_q - CntW'(1);
        // Outputs are only touched on the last iteration so partial values
        // never leak onto result_o/remainder_o.
        if (cnt_q == CntW'(1)) begin
          result_d    = quot_next;
          remainder_d = prem_next;
          ovf_d       = 1'b0;
          err_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      result_q    <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      prem_q      <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      prem_q      <= prem_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
    end
  end

  assign result_o    = result_q;
  assign remainder_o = remainder_q;
  assign busy_o      = (state_q == StDiv);
  assign done_o      = done_q;
  assign ovf_o       = ovf_q;
  assign err_o       = err_q;

endmodule
